// File: rtl/ifetch_if.sv
// ifetch_if: fetch-unit bus bundle (redirect, imem request/response, decode stream)
interface ifetch_if;
    logic        redir_w_i;
    logic [31:0] redir_pc_w_i;
    logic        imem_req_w_o;
    logic [31:0] imem_addr_w_o;
    logic        imem_gnt_w_i;
    logic        imem_rvalid_w_i;
    logic [31:0] imem_rdata_w_i;
    logic        instr_valid_w_o;
    logic [31:0] instr_w_o;
    logic [31:0] instr_pc_w_o;
    logic        instr_ready_w_i;
    modport master (
        input  redir_w_i, redir_pc_w_i, imem_gnt_w_i, imem_rvalid_w_i, imem_rdata_w_i, instr_ready_w_i,
        output imem_req_w_o, imem_addr_w_o, instr_valid_w_o, instr_w_o, instr_pc_w_o
    );
    modport slave (
        output redir_w_i, redir_pc_w_i, imem_gnt_w_i, imem_rvalid_w_i, imem_rdata_w_i, instr_ready_w_i,
        input  imem_req_w_o, imem_addr_w_o, instr_valid_w_o, instr_w_o, instr_pc_w_o
    );
endinterface

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with credit-limited imem requests and a pc/instr FIFO
// Redirects flush the FIFO and count the in-flight responses that must be squashed.
module ifetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input logic      clk_w_i,
    input logic      res_w_i_l,
    ifetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, count_q, count_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];
    logic [31:0]   ins_mem_d [DEPTH];
    logic [CW:0]   credit;
    logic          req, fire, push, pop, valid, rv;
    always_comb begin
        rv = bus.imem_rvalid_w_i;
        // in-flight plus buffered never exceeds DEPTH, so a push always finds room
        credit = {1'b0, out_q} + {1'b0, count_q};
        req = res_w_i_l & ~bus.redir_w_i & (int'(credit) < DEPTH);
        valid = (count_q != '0) & ~bus.redir_w_i;
        fire = req & bus.imem_gnt_w_i;
        push = rv & (disc_q == '0) & ~bus.redir_w_i;
        pop = valid & bus.instr_ready_w_i;
        fpc_d = fire ? fpc_q + 32'd4 : fpc_q;
        rpc_d = push ? rpc_q + 32'd4 : rpc_q;
        out_d = out_q + CW'(fire) - CW'(rv);
        disc_d = (rv && disc_q != '0) ? disc_q - CW'(1) : disc_q;
        count_d = count_q + CW'(push) - CW'(pop);
        wr_d = push ? wr_q + AW'(1) : wr_q;
        rd_d = pop ? rd_q + AW'(1) : rd_q;
        pc_mem_d = pc_mem_q;
        ins_mem_d = ins_mem_q;
        if (push) begin
            pc_mem_d[wr_q] = rpc_q;
            ins_mem_d[wr_q] = bus.imem_rdata_w_i;
        end
        if (bus.redir_w_i) begin
            fpc_d = bus.redir_pc_w_i;
            rpc_d = bus.redir_pc_w_i;
            disc_d = out_q - CW'(rv);
            count_d = '0;
            wr_d = '0;
            rd_d = '0;
        end
    end
    always_ff @(posedge clk_w_i) begin
        if (!res_w_i_l) begin
            fpc_q <= RESET_VECTOR;
            rpc_q <= RESET_VECTOR;
            out_q <= '0;
            disc_q <= '0;
            count_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            fpc_q <= fpc_d;
            rpc_q <= rpc_d;
            out_q <= out_d;
            disc_q <= disc_d;
            count_q <= count_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        pc_mem_q <= pc_mem_d;
        ins_mem_q <= ins_mem_d;
    end
    assign bus.imem_req_w_o = req;
    assign bus.imem_addr_w_o = fpc_q;
    assign bus.instr_valid_w_o = valid;
    assign bus.instr_w_o = ins_mem_q[rd_q];
    assign bus.instr_pc_w_o = pc_mem_q[rd_q];
endmodule
